// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed N-digit BCD seven-segment driver with shadow register.
// Optional leading-zero blanking enabled by defining SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [IW-1:0]         digit_idx
);
  localparam logic AL = (ACTIVE_LOW != 0);
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_bcd;
  logic [N_DIGITS-1:0]   r_dps;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  w_tick;
  logic [3:0]            w_digit;
  logic [6:0]            w_seg;
  logic [N_DIGITS-1:0]   w_onehot;
  logic [N_DIGITS-1:0]   w_blank;
  logic                  w_zrun;
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0:    dec = 7'b0111111;
      4'd1:    dec = 7'b0000110;
      4'd2:    dec = 7'b1011011;
      4'd3:    dec = 7'b1001111;
      4'd4:    dec = 7'b1100110;
      4'd5:    dec = 7'b1101101;
      4'd6:    dec = 7'b1111101;
      4'd7:    dec = 7'b0000111;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1101111;
      default: dec = 7'b1000000;
    endcase
  endfunction
  assign w_tick   = en && (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_digit  = r_bcd[4*int'(r_idx) +: 4];
  assign w_seg    = dec(w_digit);
  assign w_onehot = N_DIGITS'(1) << r_idx;
`ifdef SSD_LEADING_ZERO_BLANK_EN
  // a digit blanks when it and every more significant digit are zero; digit 0 never blanks
  always_comb begin
    w_blank = '0;
    w_zrun  = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      w_zrun     = w_zrun & (r_bcd[4*k +: 4] == 4'd0);
      w_blank[k] = w_zrun;
    end
  end
`else
  assign w_blank = '0;
  assign w_zrun  = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_bcd <= '0;
      r_dps <= '0;
      r_an  <= {N_DIGITS{AL}};
      r_seg <= {7{AL}};
      r_dp  <= AL;
    end else begin
      if (en) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      if (load) begin
        r_bcd <= bcd_in;
        r_dps <= dp_in;
      end
      r_an  <= {N_DIGITS{AL}} ^ (en ? w_onehot : '0);
      r_seg <= {7{AL}} ^ ((en && !w_blank[r_idx]) ? w_seg : 7'd0);
      r_dp  <= AL ^ (en && r_dps[r_idx]);
    end
  end
  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign digit_idx = r_idx;
endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Parametrised, time-multiplexed multi-digit seven-segment display driver.
- Successor to the single-digit BCD decoder: it decodes N_DIGITS BCD digits and scans them one at a time onto shared segment lines with per-digit anode enables.
- Digit values and decimal points are captured into a shadow register on a load strobe, so upstream logic (counters, calculators) can change freely between loads.
- Sits between datapath logic and the board's common-anode display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, clock cycles each digit is held before advancing (>=2)
- ACTIVE_LOW, 1, 1 = an/seg/dp driven active-low (common-anode board); 0 = active-high

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable; 0 blanks the display and freezes scanning
- load  in  1  single-cycle strobe; captures bcd_in and dp_in into the shadow register
- bcd_in  in  4*N_DIGITS  digit k occupies bits [4k+3:4k]; digit 0 is rightmost and least significant
- dp_in  in  N_DIGITS  decimal point request per digit
- an  out  N_DIGITS  anode enables, one-hot when active
- seg  out  7  segments; seg[0]=a ... seg[6]=g
- dp  out  1  decimal point segment
- digit_idx  out  $clog2(N_DIGITS) (min 1)  index of the digit currently driven

Behaviour:
- One clock domain, clk; rst is synchronous and active-high.
- Reset values:
  - refresh counter = 0, digit_idx = 0, shadow digits = 0, shadow dp = 0.
  - an, seg and dp all inactive (all 1s when ACTIVE_LOW=1, all 0s otherwise).
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 while en=1, then wraps to 0.
  - scan_tick is an internal signal, asserted when count == REFRESH_DIV-1 and en=1.
  - On scan_tick, digit_idx advances by 1 and wraps from N_DIGITS-1 to 0.
- Shadow register:
  - On load=1, bcd_in and dp_in are captured at that edge.
  - load is honoured regardless of en.
- Decode, per BCD digit value:
  - 0-9 map to standard patterns. Active-high {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Values 10-15 show a dash (segment g only).
  - The active-low variant is the bitwise inverse.
- Output registers:
  - an, seg and dp are registered.
  - They reflect digit_idx and the shadow contents as of the previous edge, so there is 1-cycle latency from an idx or load change to the pins.
  - an has exactly one active bit, at position digit_idx.
- en=0:
  - Counter and digit_idx hold their values.
  - an, seg and dp go inactive on the next edge.
  - When en returns to 1, scanning resumes from the held digit_idx and count.
- Boundary conditions:
  - load coincident with scan_tick: both take effect; the newly indexed digit shows the newly loaded value one cycle later.
  - rst mid-scan: every register returns to its reset value on that edge; rst has priority over load and en.
  - N_DIGITS=1: digit_idx stays 0 and an is constantly active while en=1.
- No glitches on an: it changes only at clock edges and never has two bits active at once.

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 is blanked (seg inactive, and dp inactive unless its own dp bit is set) when that digit and every higher digit in the shadow register are 0. Digit 0 is never blanked, so the value 0 displays as a single "0".
  - The blank pattern is evaluated from the shadow register, so it follows the same 1-cycle output latency.
  - an still scans normally.
- Not defined: every digit is always decoded and displayed, leading zeros included.

Test Plan (N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1):
1. Reset and scan: rst held 3 cycles, then en=1, load with bcd_in=16'h1234.
   - Directly after reset: an=1111, seg=1111111, dp=1.
   - Then an steps through 1110, 1101, 1011, 0111 and back to 1110, every 4 cycles.
   - seg shows 4, 3, 2, 1 on the matching anodes (e.g. an=1110 with seg=0011001).
2. Invalid BCD and dp: load bcd_in=16'hA000, dp_in=4'b0010.
   - Digit 3 shows a dash: seg=0111111.
   - dp=0 only while an=1101.
3. Enable gating: deassert en for 10 cycles mid-digit.
   - an=1111 from the next edge onward.
   - digit_idx is unchanged.
   - On re-enable, the same digit resumes and completes its remaining count.
4. Load on scan_tick: load 16'h0009 on the exact cycle digit_idx wraps 3->0.
   - The next cycle shows an=1110 with seg=0010000 (digit 9).
5. Reset mid-operation: assert rst while digit_idx=2.
   - The next edge gives digit_idx=0, shadow=0 and all outputs inactive.
6. SSD_LEADING_ZERO_BLANK_EN defined: load 16'h0050.
   - Digits 3 and 2 are blank (seg=1111111).
   - Digits 1 and 0 show 5 and 0.
   - Then load 16'h0000: only digit 0 shows "0".
